// File: rtl/alarm_unit.sv
// Alarm stage for the wall clock: stores an alarm time, compares it against the
// running time on each second tick, and drives ring/snooze control plus a buzzer tone.
module alarm_unit #(
   parameter int BEEP_HALF  = 25000,
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_sec_tick,
   input  logic [4:0] i_cur_hour,
   input  logic [5:0] i_cur_min,
   input  logic [5:0] i_cur_sec,
   input  logic       i_set_mode,
   input  logic       i_inc_min,
   input  logic       i_dec_min,
   input  logic       i_inc_hour,
   input  logic       i_dec_hour,
   input  logic       i_arm_toggle,
   input  logic       i_snooze,
   input  logic       i_stop,
   output logic [4:0] o_alarm_hour,
   output logic [5:0] o_alarm_min,
   output logic       o_armed,
   output logic       o_ringing,
   output logic       o_buzzer,
   output logic [1:0] o_state
);

   typedef enum logic [1:0] {
      S_DISARMED = 2'b00,
      S_ARMED    = 2'b01,
      S_RINGING  = 2'b10,
      S_SNOOZE   = 2'b11
   } state_t;

   localparam int SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
   localparam int SEC_W   = $clog2(SEC_MAX) + 1;
   localparam int BEEP_W  = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;

   localparam logic [SEC_W-1:0]  RING_LAST   = SEC_W'(RING_SEC - 1);
   localparam logic [SEC_W-1:0]  SNOOZE_LAST = SEC_W'(SNOOZE_SEC - 1);
   localparam logic [BEEP_W-1:0] BEEP_LAST   = BEEP_W'(BEEP_HALF - 1);

   state_t            r_state;
   state_t            w_next;
   logic [SEC_W-1:0]  r_sec_cnt;
   logic [BEEP_W-1:0] r_beep_cnt;
   logic [4:0]        r_alarm_hour;
   logic [5:0]        r_alarm_min;
   logic              r_armed;
   logic              r_ringing;
   logic              r_buzzer;
   logic              w_match;
   logic              w_edit;

   assign w_match = (i_cur_hour == r_alarm_hour) && (i_cur_min == r_alarm_min) &&
                    (i_cur_sec == 6'd0);
   assign w_edit  = i_set_mode && ((r_state == S_DISARMED) || (r_state == S_ARMED));

   // Event priority: arm_toggle, then stop, then snooze, then second-tick events.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_DISARMED: begin
            if (i_arm_toggle) w_next = S_ARMED;
         end
         S_ARMED: begin
            if (i_arm_toggle)                w_next = S_DISARMED;
            else if (i_sec_tick && w_match) w_next = S_RINGING;
         end
         S_RINGING: begin
            if (i_arm_toggle)    w_next = S_DISARMED;
            else if (i_stop)     w_next = S_ARMED;
            else if (i_snooze)   w_next = S_SNOOZE;
            else if (i_sec_tick && (r_sec_cnt == RING_LAST)) w_next = S_ARMED;
         end
         S_SNOOZE: begin
            if (i_arm_toggle)    w_next = S_DISARMED;
            else if (i_stop)     w_next = S_ARMED;
            else if (i_sec_tick && (r_sec_cnt == SNOOZE_LAST)) w_next = S_RINGING;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_DISARMED;
         r_armed      <= 1'b0;
         r_ringing    <= 1'b0;
         r_sec_cnt    <= '0;
         r_beep_cnt   <= '0;
         r_buzzer     <= 1'b0;
         r_alarm_hour <= 5'd0;
         r_alarm_min  <= 6'd0;
      end else begin
         r_state   <= w_next;
         r_armed   <= (w_next != S_DISARMED);
         r_ringing <= (w_next == S_RINGING);

         if (w_next != r_state)
            r_sec_cnt <= '0;
         else if (i_sec_tick && ((r_state == S_RINGING) || (r_state == S_SNOOZE)))
            r_sec_cnt <= r_sec_cnt + 1'b1;

         // The tone restarts from a low phase on every entry into ringing.
         if ((w_next == S_RINGING) && (r_state == S_RINGING)) begin
            if (r_beep_cnt == BEEP_LAST) begin
               r_beep_cnt <= '0;
               r_buzzer   <= ~r_buzzer;
            end else begin
               r_beep_cnt <= r_beep_cnt + 1'b1;
            end
         end else begin
            r_beep_cnt <= '0;
            r_buzzer   <= 1'b0;
         end

         if (w_edit) begin
            if (i_inc_min && !i_dec_min)
               r_alarm_min <= (r_alarm_min == 6'd59) ? 6'd0 : r_alarm_min + 6'd1;
            else if (i_dec_min && !i_inc_min)
               r_alarm_min <= (r_alarm_min == 6'd0) ? 6'd59 : r_alarm_min - 6'd1;
            if (i_inc_hour && !i_dec_hour)
               r_alarm_hour <= (r_alarm_hour == 5'd23) ? 5'd0 : r_alarm_hour + 5'd1;
            else if (i_dec_hour && !i_inc_hour)
               r_alarm_hour <= (r_alarm_hour == 5'd0) ? 5'd23 : r_alarm_hour - 5'd1;
         end
      end
   end

   assign o_state      = r_state;
   assign o_armed      = r_armed;
   assign o_ringing    = r_ringing;
   assign o_buzzer     = r_buzzer;
   assign o_alarm_hour = r_alarm_hour;
   assign o_alarm_min  = r_alarm_min;

endmodule
